// File: rtl/uart_rx_cmd_ctrl.sv
// uart_rx_cmd_ctrl: turns framed command bytes from the receive UART into
// sequential register writes. A frame is SYNC_BYTE, address, length, payload
// and an XOR checksum over address, length and payload. The payload is
// buffered, then issued once the checksum matches.
// Optional build macro: UART_RX_CMD_STATS_EN adds the ok/err frame counters
// and their stats_clr input.
module uart_rx_cmd_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned MAX_LEN     = 16,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ready,
  output logic              frame_ok,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic              rx_drop,
`ifdef UART_RX_CMD_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       ok_cnt,
  output logic [15:0]       err_cnt,
`endif
  output logic              busy
);

  localparam int unsigned IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned BUF_D     = 1 << IDX_W;
  localparam int unsigned TO_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    ADDR    = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CHECK   = 3'd4,
    WRITE   = 3'd5
  } state_t;

  state_t            state;
  logic [7:0]        buf_mem [BUF_D];
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        len_q;
  logic [7:0]        chk_q;
  logic [IDX_W-1:0]  idx;
  logic [TO_W-1:0]   to_cnt;
  logic              timed_c;
  logic              to_exp_c;
  logic              last_idx_c;

  // Inter-byte timeout applies only while a frame is being received
  assign timed_c    = (state == ADDR) || (state == LEN) ||
                      (state == PAYLOAD) || (state == CHECK);
  assign to_exp_c   = timed_c && !rx_done && (to_cnt == TO_LAST);
  assign last_idx_c = (8'(idx) == (len_q - 8'd1));

  // Payload buffer; contents are don't-care outside a frame, so no reset
  always_ff @(posedge clk) begin
    if ((state == PAYLOAD) && rx_done) begin
      buf_mem[idx] <= rx_data;
    end
  end

  // Inter-byte idle counter, cleared by every received byte
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (!timed_c || rx_done) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Frame FSM with registered write port and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HUNT;
      base_addr <= '0;
      len_q     <= '0;
      chk_q     <= '0;
      idx       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      rx_drop   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      rx_drop   <= 1'b0;
      case (state)
        HUNT: begin
          if (rx_done && (rx_data == SYNC_BYTE)) begin
            state <= ADDR;
            busy  <= 1'b1;
          end
        end
        ADDR: begin
          if (rx_done) begin
            base_addr <= ADDR_W'(rx_data);
            chk_q     <= rx_data;
            state     <= LEN;
          end
        end
        LEN: begin
          if (rx_done) begin
            if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
              busy      <= 1'b0;
              state     <= HUNT;
            end else begin
              len_q <= rx_data;
              chk_q <= chk_q ^ rx_data;
              idx   <= '0;
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (rx_done) begin
            chk_q <= chk_q ^ rx_data;
            idx   <= idx + IDX_W'(1);
            if (last_idx_c) begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (rx_done) begin
            if (rx_data == chk_q) begin
              idx     <= '0;
              wr_en   <= 1'b1;
              wr_addr <= base_addr;
              wr_data <= buf_mem[IDX_W'(0)];
              state   <= WRITE;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CHK;
              busy      <= 1'b0;
              state     <= HUNT;
            end
          end
        end
        WRITE: begin
          // Bytes arriving while writes drain are discarded, sync included
          if (rx_done) begin
            rx_drop <= 1'b1;
          end
          if (wr_ready) begin
            if (last_idx_c) begin
              wr_en    <= 1'b0;
              frame_ok <= 1'b1;
              busy     <= 1'b0;
              state    <= HUNT;
            end else begin
              idx     <= idx + IDX_W'(1);
              wr_addr <= wr_addr + ADDR_W'(1);
              wr_data <= buf_mem[idx + IDX_W'(1)];
            end
          end
        end
        default: begin
          wr_en <= 1'b0;
          busy  <= 1'b0;
          state <= HUNT;
        end
      endcase
      // Expiry only fires without rx_done, so it never overrides a received byte
      if (to_exp_c) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        busy      <= 1'b0;
        state     <= HUNT;
      end
    end
  end

`ifdef UART_RX_CMD_STATS_EN
  // Saturating frame counters; a clear beats a coincident increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else if (stats_clr) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (frame_ok && (ok_cnt != 16'hFFFF)) begin
        ok_cnt <= ok_cnt + 16'd1;
      end
      if (frame_err && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Bench for uart_rx_cmd_ctrl: directed frames plus random byte streams,
// compared against a frame-level reference model of the command protocol.
module tb_uart_rx_cmd_ctrl;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TO_CYC  = 64;
  localparam logic [7:0]  SYNC    = 8'hA5;

  typedef struct {
    logic [7:0]  b;
    int unsigned gap;
  } rx_item_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       wr_ready = 1'b1;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       rx_drop;
  logic       busy;
`ifdef UART_RX_CMD_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;
  int          exp_okc = 0;
  int          exp_errc = 0;
`endif

  int       n_checks = 0;
  int       n_fail = 0;
  int       cyc = 0;
  int       ready_mode = 1;
  int       last_drive_cyc = 0;

  rx_item_t txq[$];
  wr_t      exp_wr[$];
  wr_t      act_wr[$];
  int       act_wr_cyc[$];
  int       exp_ok, exp_err;
  logic [1:0] mdl_code = 2'd0;
  int       got_ok = 0, got_err = 0, got_drop = 0, ok_cyc = 0;
  logic     stall_prev = 1'b0;
  logic [7:0] stall_addr = 8'h00, stall_data = 8'h00;

  uart_rx_cmd_ctrl #(
    .ADDR_W      (8),
    .MAX_LEN     (MAX_LEN),
    .SYNC_BYTE   (SYNC),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .rx_drop   (rx_drop),
`ifdef UART_RX_CMD_STATS_EN
    .stats_clr (stats_clr),
    .ok_cnt    (ok_cnt),
    .err_cnt   (err_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Write-port ready pattern
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       wr_ready = 1'($urandom_range(0, 1));
      1:       wr_ready = 1'b1;
      2:       wr_ready = 1'b0;
      default: wr_ready = ((cyc % 4) == 0);
    endcase
  end

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_ok || frame_err) check("ok_err_excl", 32'(frame_ok & frame_err), 32'd0);
      if (stall_prev && wr_en) begin
        check("wr_addr_stable", 32'(wr_addr), 32'(stall_addr));
        check("wr_data_stable", 32'(wr_data), 32'(stall_data));
      end
      if (wr_en && wr_ready) begin
        act_wr.push_back('{wr_addr, wr_data});
        act_wr_cyc.push_back(cyc);
      end
      if (frame_ok) begin
        got_ok++;
        ok_cyc = cyc;
      end
      if (frame_err) got_err++;
      if (rx_drop) got_drop++;
      stall_prev = wr_en && !wr_ready;
      stall_addr = wr_addr;
      stall_data = wr_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Reference model: parse the byte stream frame by frame
  function automatic void run_model();
    int n, i, j, need;
    bit to, bad_len;
    logic [7:0] fb[$];
    logic [7:0] x;
    exp_wr.delete();
    exp_ok = 0;
    exp_err = 0;
    n = txq.size();
    i = 0;
    while (i < n) begin
      if (txq[i].b != SYNC) begin
        i++;
      end else begin
        fb.delete();
        j = i + 1;
        need = 2;
        to = 0;
        bad_len = 0;
        while (fb.size() < need) begin
          if (j >= n || txq[j].gap >= TO_CYC) begin
            to = 1;
            break;
          end
          fb.push_back(txq[j].b);
          j++;
          if (fb.size() == 2) begin
            if (fb[1] == 8'd0 || fb[1] > MAX_LEN) begin
              bad_len = 1;
              break;
            end
            need = 3 + int'(fb[1]);
          end
        end
        if (to) begin
          exp_err++;
          mdl_code = 2'd3;
        end else if (bad_len) begin
          exp_err++;
          mdl_code = 2'd1;
        end else begin
          x = 8'h00;
          for (int k = 0; k < need - 1; k++) x ^= fb[k];
          if (fb[need-1] == x) begin
            exp_ok++;
            for (int k = 0; k < int'(fb[1]); k++)
              exp_wr.push_back('{8'(int'(fb[0]) + k), fb[2+k]});
          end else begin
            exp_err++;
            mdl_code = 2'd2;
          end
        end
        i = j;
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_data = b;
    rx_done = 1'b1;
    last_drive_cyc = cyc;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_wait", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic add_byte(input logic [7:0] b, input int unsigned gap);
    txq.push_back('{b, gap});
  endtask

  task automatic check_writes(input string name);
    int m;
    check($sformatf("%s wr_count", name), 32'(act_wr.size()), 32'(exp_wr.size()));
    m = (act_wr.size() < exp_wr.size()) ? act_wr.size() : exp_wr.size();
    for (int k = 0; k < m; k++) begin
      check($sformatf("%s wr_addr[%0d]", name, k), 32'(act_wr[k].addr), 32'(exp_wr[k].addr));
      check($sformatf("%s wr_data[%0d]", name, k), 32'(act_wr[k].data), 32'(exp_wr[k].data));
    end
  endtask

  task automatic run_txn(input string name);
    int ok0, err0;
    ok0 = got_ok;
    err0 = got_err;
    act_wr.delete();
    act_wr_cyc.delete();
    run_model();
    foreach (txq[k]) send_byte(txq[k].b, txq[k].gap);
    wait_idle();
    check($sformatf("%s frame_ok", name), 32'(got_ok - ok0), 32'(exp_ok));
    check($sformatf("%s frame_err", name), 32'(got_err - err0), 32'(exp_err));
    check($sformatf("%s err_code", name), 32'(err_code), 32'(mdl_code));
    check_writes(name);
`ifdef UART_RX_CMD_STATS_EN
    exp_okc += exp_ok;
    exp_errc += exp_err;
    check($sformatf("%s ok_cnt", name), 32'(ok_cnt), 32'(exp_okc));
    check($sformatf("%s err_cnt", name), 32'(err_cnt), 32'(exp_errc));
`endif
  endtask

  function automatic int unsigned rgap();
    return $urandom_range(0, 2);
  endfunction

  task automatic build_random();
    int nz, kind, len, s, p;
    logic [7:0] addr, x, b;
    txq.delete();
    nz = $urandom_range(0, 2);
    for (int k = 0; k < nz; k++) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h00;
      add_byte(b, $urandom_range(0, 3));
    end
    s = nz;
    add_byte(SYNC, $urandom_range(0, 3));
    kind = $urandom_range(0, 9);
    addr = 8'($urandom_range(0, 255));
    if (kind == 5)
      len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX_LEN + 1, 255));
    else
      len = $urandom_range(1, MAX_LEN);
    add_byte(addr, rgap());
    add_byte(8'(len), rgap());
    if (kind != 5) begin
      x = addr ^ 8'(len);
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom_range(0, 255));
        x ^= b;
        add_byte(b, rgap());
      end
      if (kind == 6) add_byte(x ^ 8'($urandom_range(1, 255)), rgap());
      else if (kind != 9) add_byte(x, rgap());
    end
    if (kind == 7 || kind == 8) begin
      p = $urandom_range(s + 1, txq.size() - 1);
      txq[p].gap = (kind == 7) ? TO_CYC + $urandom_range(0, 3) : TO_CYC - 1;
    end
  endtask

  task automatic build_good(input logic [7:0] addr, input int len);
    logic [7:0] x, b;
    txq.delete();
    add_byte(SYNC, 0);
    add_byte(addr, 0);
    add_byte(8'(len), 0);
    x = addr ^ 8'(len);
    for (int k = 0; k < len; k++) begin
      b = 8'(8'h11 * (k + 1));
      x ^= b;
      add_byte(b, 0);
    end
    add_byte(x, 0);
  endtask

  initial begin
    int ok0, err0, drop0;

    repeat (3) @(posedge clk);
    #1;
    check("rst wr_en", 32'(wr_en), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst frame_ok", 32'(frame_ok), 32'd0);
    check("rst frame_err", 32'(frame_err), 32'd0);
    check("rst rx_drop", 32'(rx_drop), 32'd0);
    check("rst err_code", 32'(err_code), 32'd0);
    check("rst wr_addr", 32'(wr_addr), 32'd0);
    check("rst wr_data", 32'(wr_data), 32'd0);
`ifdef UART_RX_CMD_STATS_EN
    check("rst ok_cnt", 32'(ok_cnt), 32'd0);
    check("rst err_cnt", 32'(err_cnt), 32'd0);
`endif
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Good frame, ready tied high: minimum latency
    ready_mode = 1;
    txq.delete();
    add_byte(SYNC, 0); add_byte(8'h10, 0); add_byte(8'h03, 0);
    add_byte(8'h11, 0); add_byte(8'h22, 0); add_byte(8'h33, 0); add_byte(8'h13, 0);
    run_txn("good");
    check("good first_wr_cyc", 32'(act_wr_cyc.size() > 0 ? act_wr_cyc[0] : -1), 32'(last_drive_cyc + 1));
    if (act_wr_cyc.size() == 3)
      check("good back_to_back", 32'(act_wr_cyc[2] - act_wr_cyc[0]), 32'd2);
    check("good ok_cyc", 32'(ok_cyc), 32'(last_drive_cyc + 1 + 3));

    // Address wrap with backpressure
    ready_mode = 3;
    txq.delete();
    add_byte(SYNC, 0); add_byte(8'hFE, 0); add_byte(8'h02, 0);
    add_byte(8'hAA, 0); add_byte(8'hBB, 0); add_byte(8'hED, 0);
    run_txn("wrap");

    // Bad length, then bad checksum
    ready_mode = 1;
    txq.delete();
    add_byte(SYNC, 0); add_byte(8'h00, 0); add_byte(8'h00, 0);
    run_txn("badlen");
    txq.delete();
    add_byte(SYNC, 0); add_byte(8'h20, 0); add_byte(8'h01, 0);
    add_byte(8'h55, 0); add_byte(8'h00, 0);
    run_txn("badchk");

    // Noise, then timeout after the length byte's predecessor
    txq.delete();
    add_byte(8'h00, 0); add_byte(8'hFF, 2); add_byte(SYNC, 1); add_byte(8'h40, 0);
    run_txn("timeout");
    check("timeout busy", 32'(busy), 32'd0);

    // Byte on the exact expiry cycle wins
    txq.delete();
    add_byte(SYNC, 0); add_byte(8'h40, TO_CYC - 1); add_byte(8'h01, TO_CYC - 1);
    add_byte(8'h5A, TO_CYC - 1); add_byte(8'h40 ^ 8'h01 ^ 8'h5A, TO_CYC - 1);
    run_txn("expiry_edge");

    // Overrun: sync byte during a stalled write burst is dropped
    ready_mode = 2;
    build_good(8'h30, 3);
    ok0 = got_ok;
    err0 = got_err;
    act_wr.delete();
    run_model();
    foreach (txq[k]) send_byte(txq[k].b, txq[k].gap);
    repeat (2) @(posedge clk);
    #1;
    check("ovr wr_en", 32'(wr_en), 32'd1);
    drop0 = got_drop;
    send_byte(SYNC, 0);
    @(posedge clk);
    #1;
    check("ovr rx_drop", 32'(got_drop - drop0), 32'd1);
    ready_mode = 1;
    wait_idle();
    check("ovr frame_ok", 32'(got_ok - ok0), 32'd1);
    check("ovr frame_err", 32'(got_err - err0), 32'd0);
    check_writes("ovr");
    repeat (4) @(posedge clk);
    #1;
    check("ovr no_new_frame", 32'(busy), 32'd0);
`ifdef UART_RX_CMD_STATS_EN
    exp_okc += 1;
    check("ovr ok_cnt", 32'(ok_cnt), 32'(exp_okc));
`endif

    // Reset mid-write
    ready_mode = 2;
    build_good(8'h70, 4);
    foreach (txq[k]) send_byte(txq[k].b, txq[k].gap);
    repeat (2) @(posedge clk);
    #1;
    check("rstw wr_en_before", 32'(wr_en), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstw wr_en_async", 32'(wr_en), 32'd0);
    check("rstw busy_async", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mdl_code = 2'd0;
`ifdef UART_RX_CMD_STATS_EN
    exp_okc = 0;
    exp_errc = 0;
`endif
    ready_mode = 1;
    build_good(8'h80, 5);
    run_txn("after_rst");

    // Random streams
    for (int t = 0; t < 60; t++) begin
      ready_mode = $urandom_range(0, 3);
      if (ready_mode == 2) ready_mode = 0;
      build_random();
      run_txn($sformatf("rnd%0d", t));
    end

`ifdef UART_RX_CMD_STATS_EN
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    check("clr ok_cnt", 32'(ok_cnt), 32'd0);
    check("clr err_cnt", 32'(err_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_cmd_ctrl.md
Name: uart_rx_cmd_ctrl

Overview:
- Command-frame controller that sits on the receive UART's byte output (byte bus plus one-cycle done strobe).
- Hunts for a sync byte, then assembles and buffers a frame (address, length, payload, checksum) and verifies it.
- Issues the payload as sequential register writes over a valid/ready write port.
- Connects the serial host link to the on-chip register file.

Parameters:
- ADDR_W, 8, width of write address and of the frame address byte; must be 8.
- MAX_LEN, 16, maximum payload bytes per frame (1..255); sets the internal buffer depth.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 4096, idle clk cycles allowed between bytes inside a frame before abort.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- rx_data, input, 8, received byte; valid only when rx_done=1.
- rx_done, input, 1, one-cycle strobe: rx_data holds a new byte.
- wr_en, output, 1, write request; held until accepted.
- wr_addr, output, ADDR_W, write address.
- wr_data, output, 8, write data.
- wr_ready, input, 1, write accepted when wr_en&wr_ready at posedge.
- frame_ok, output, 1, one-cycle pulse: frame fully written.
- frame_err, output, 1, one-cycle pulse: frame aborted.
- err_code, output, 2, 1=bad length, 2=bad checksum, 3=timeout; holds last error value.
- rx_drop, output, 1, one-cycle pulse: byte discarded during WRITE.
- busy, output, 1, high in every state except HUNT.

Behaviour:
- Reset (async, reset_n=0): state HUNT.
  - All outputs 0, counters 0, err_code 0.
  - Buffer contents undefined; no clearing required.
- All outputs are registered.
- State HUNT:
  - On rx_done with rx_data==SYNC_BYTE: go to ADDR and clear the timeout counter.
  - Any other byte is ignored silently.
- State ADDR: on rx_done, latch base address; checksum := rx_data; go to LEN.
- State LEN: on rx_done:
  - If rx_data==0 or rx_data>MAX_LEN: frame_err=1, err_code=1 next cycle, go to HUNT.
  - Otherwise latch len; checksum ^= rx_data; idx:=0; go to PAYLOAD.
- State PAYLOAD: on each rx_done:
  - buf[idx]:=rx_data; checksum ^= rx_data; idx++.
  - When idx reaches len-1 on this byte: go to CHECK.
- State CHECK: on rx_done:
  - If rx_data==checksum: go to WRITE; idx:=0; wr_en=1 next cycle with wr_addr=base, wr_data=buf[0].
  - Else: frame_err=1, err_code=2, go to HUNT.
- Timeout (ADDR, LEN, PAYLOAD, CHECK only):
  - Counter increments each clk and clears on rx_done.
  - On reaching TIMEOUT_CYC-1 without rx_done: frame_err=1, err_code=3, go to HUNT.
  - If rx_done and expiry occur in the same cycle, the byte wins: no timeout.
- State WRITE:
  - wr_en stays high; wr_addr/wr_data are stable while wr_ready=0.
  - On handshake: idx++, wr_addr:=base+idx mod 2^ADDR_W (wraps 8'hFF->8'h00), wr_data:=buf[idx].
  - After the handshake of the last byte (idx==len-1): wr_en=0, frame_ok=1 the next cycle, go to HUNT.
  - No timeout in WRITE.
  - rx_done in WRITE: byte discarded, rx_drop=1 next cycle; this includes a sync byte, which does not start a frame.
- Minimum latency: checksum rx_done at cycle N gives wr_en=1 at N+1. With wr_ready tied high, frame_ok pulses at N+1+len.
- frame_ok and frame_err are never high together.
- Reset mid-frame or mid-write: immediate return to the reset state; wr_en drops asynchronously; the partial frame is lost.

Optional Feature:
- Macro: UART_RX_CMD_STATS_EN.
- Defined: adds outputs ok_cnt[15:0] and err_cnt[15:0].
  - ok_cnt increments on frame_ok; err_cnt increments on frame_err.
  - Both saturate at 16'hFFFF and reset to 0.
  - Adds input stats_clr (1 bit): synchronous clear of both counters. If stats_clr coincides with an increment event, the clear wins.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Good frame, wr_ready=1: bytes A5,10,03,11,22,33,chk=10^03^11^22^33=0x13 -> writes (10,11),(11,22),(12,33) on consecutive cycles; one frame_ok; err_code stays 0.
- Address wrap with backpressure: A5,FE,02,AA,BB,chk=0xFE^02^AA^BB=0xED, wr_ready low 3 cycles per write -> writes (FE,AA),(FF,BB); wr_addr/wr_data stable while stalled; then frame_ok.
- Bad length then bad checksum: A5,00,00 -> frame_err, err_code=1, no wr_en. Then A5,20,01,55,00 -> frame_err, err_code=2, no writes.
- Timeout and noise: leading bytes 00,FF ignored in HUNT. After A5,40, no byte for TIMEOUT_CYC cycles -> frame_err, err_code=3, busy=0. Repeat with a byte arriving exactly on the expiry cycle -> no error.
- Overrun and reset: send A5 during WRITE with wr_ready=0 -> rx_drop pulse, no new frame. Assert reset_n mid-WRITE -> wr_en=0 immediately; next good frame processes normally.
- With UART_RX_CMD_STATS_EN: 2 good + 1 bad frame -> ok_cnt=2, err_cnt=1. Pulse stats_clr -> both 0. Force err_cnt to FFFF -> stays at FFFF after a further error.
